// File: rtl/param_uop_sequencer_pkg.sv
// Shared sizing and FSM encodings for the nibble-serial micro-op sequencer and its datapath.
package param_uop_sequencer_pkg;

  localparam int P_NBITS   = 4;
  localparam int C_N_OFF   = 32 / P_NBITS;
  localparam int C_OFFBITS = $clog2(C_N_OFF);

  localparam logic [C_OFFBITS-1:0] OFF_LAST = C_OFFBITS'(C_N_OFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } seq_state_e;

  function automatic logic is_last_off(input logic [C_OFFBITS-1:0] off);
    return off == OFF_LAST;
  endfunction

endpackage

// File: rtl/param_uop_xreg.sv
// R->X pipeline register: carries one micro-op's control fields into the execute stage.
module param_uop_xreg
  import param_uop_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 r_val_i,
  input  logic [C_OFFBITS-1:0] r_off_i,
  input  logic [4:0]           r_rd_i,
  input  logic                 r_wb_en_i,
  input  logic                 r_is_sub_i,
  input  logic                 r_mem_i,
  output logic                 x_val_o,
  output logic [C_OFFBITS-1:0] x_off_o,
  output logic [4:0]           x_rd_o,
  output logic                 x_wb_en_o,
  output logic                 x_is_sub_o,
  output logic                 x_mem_o
);

  logic                 val_q;
  logic [C_OFFBITS-1:0] off_q;
  logic [4:0]           rd_q;
  logic                 wb_en_q;
  logic                 is_sub_q;
  logic                 mem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q    <= 1'b0;
      off_q    <= '0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      is_sub_q <= 1'b0;
      mem_q    <= 1'b0;
    end else begin
      val_q    <= r_val_i;
      off_q    <= r_off_i;
      rd_q     <= r_rd_i;
      wb_en_q  <= r_wb_en_i;
      is_sub_q <= r_is_sub_i;
      mem_q    <= r_mem_i;
    end
  end

  assign x_val_o    = val_q;
  assign x_off_o    = off_q;
  assign x_rd_o     = rd_q;
  assign x_wb_en_o  = wb_en_q;
  assign x_is_sub_o = is_sub_q;
  assign x_mem_o    = mem_q;

endmodule

// File: rtl/param_uop_sequencer.sv
// Expands each accepted instruction into C_N_OFF nibble micro-ops (R stage) and their
// execute-stage controls one cycle later; memory ops park in MEM_WAIT until the response.
module param_uop_sequencer
  import param_uop_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_val,
  output logic                 inst_rdy,
  input  logic [4:0]           inst_rs1,
  input  logic [4:0]           inst_rs2,
  input  logic [4:0]           inst_rd,
  input  logic                 inst_wb_en,
  input  logic                 inst_is_sub,
  input  logic                 inst_mem,
  input  logic                 dmemresp_val_Xhl,
  output logic [4:0]           rega_addr_Rhl,
  output logic [4:0]           regb_addr_Rhl,
  output logic [C_OFFBITS-1:0] a_subword_off_Rhl,
  output logic [C_OFFBITS-1:0] b_subword_off_Rhl,
  output logic [4:0]           wb_addr_Xhl,
  output logic [C_OFFBITS-1:0] wb_subword_off_Xhl,
  output logic                 wb_en_Xhl,
  output logic                 prop_carry_Xhl,
  output logic                 carry_in_1_Xhl,
  output logic                 flag_reg_en_Xhl,
  output logic                 addr_reg_en_Xhl,
  output logic                 last_uop_Xhl,
  output logic                 mem_access_Xhl
);

  seq_state_e           state_q, state_d;
  logic [C_OFFBITS-1:0] cnt_q, cnt_d;
  logic [4:0]           rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                 wb_en_q, wb_en_d, is_sub_q, is_sub_d, mem_q, mem_d;
  logic                 r_val;
  logic                 accept;
  logic                 mem_wait_live;

  logic                 x_val, x_wb_en, x_is_sub, x_mem;
  logic [C_OFFBITS-1:0] x_off;
  logic [4:0]           x_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      is_sub_q <= 1'b0;
      mem_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      wb_en_q  <= wb_en_d;
      is_sub_q <= is_sub_d;
      mem_q    <= mem_d;
    end
  end

  // The wait only becomes live once the last nibble has left X, so a response
  // coinciding with last_uop_Xhl is dropped.
  assign mem_wait_live = (state_q == ST_MEM_WAIT) && !last_uop_Xhl;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    wb_en_d  = wb_en_q;
    is_sub_d = is_sub_q;
    mem_d    = mem_q;
    inst_rdy = 1'b0;
    r_val    = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inst_rdy = 1'b1;
        accept   = inst_val;
      end
      ST_RUN: begin
        r_val = 1'b1;
        if (!is_last_off(cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (mem_q) begin
          state_d = ST_MEM_WAIT;
        end else begin
          inst_rdy = 1'b1;
          accept   = inst_val;
          state_d  = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_wait_live && dmemresp_val_Xhl) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      rs1_d    = inst_rs1;
      rs2_d    = inst_rs2;
      rd_d     = inst_rd;
      wb_en_d  = inst_wb_en;
      is_sub_d = inst_is_sub;
      mem_d    = inst_mem;
    end
  end

  assign rega_addr_Rhl     = r_val ? rs1_q : '0;
  assign regb_addr_Rhl     = r_val ? rs2_q : '0;
  assign a_subword_off_Rhl = r_val ? cnt_q : '0;
  assign b_subword_off_Rhl = r_val ? cnt_q : '0;

  param_uop_xreg u_xreg (
    .clk        (clk),
    .reset      (reset),
    .r_val_i    (r_val),
    .r_off_i    (cnt_q),
    .r_rd_i     (rd_q),
    .r_wb_en_i  (wb_en_q),
    .r_is_sub_i (is_sub_q),
    .r_mem_i    (mem_q),
    .x_val_o    (x_val),
    .x_off_o    (x_off),
    .x_rd_o     (x_rd),
    .x_wb_en_o  (x_wb_en),
    .x_is_sub_o (x_is_sub),
    .x_mem_o    (x_mem)
  );

  assign wb_en_Xhl          = x_val & x_wb_en & ~x_mem;
  assign prop_carry_Xhl     = x_val & (x_off != '0);
  assign carry_in_1_Xhl     = x_val & (x_off == '0) & x_is_sub;
  assign flag_reg_en_Xhl    = x_val;
  assign addr_reg_en_Xhl    = x_val & x_mem;
  assign last_uop_Xhl       = x_val & is_last_off(x_off);
  assign wb_addr_Xhl        = x_val ? x_rd : '0;
  assign wb_subword_off_Xhl = x_val ? x_off : '0;
  assign mem_access_Xhl     = mem_wait_live;

endmodule

// File: tb/tb_param_uop_sequencer.sv
// Directed bench for param_uop_sequencer: ALU, back-to-back, memory and reset-abort sequences.
module tb_param_uop_sequencer;
  import param_uop_sequencer_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 inst_val;
  logic                 inst_rdy;
  logic [4:0]           inst_rs1, inst_rs2, inst_rd;
  logic                 inst_wb_en, inst_is_sub, inst_mem;
  logic                 dmemresp_val_Xhl;
  logic [4:0]           rega_addr_Rhl, regb_addr_Rhl;
  logic [C_OFFBITS-1:0] a_subword_off_Rhl, b_subword_off_Rhl;
  logic [4:0]           wb_addr_Xhl;
  logic [C_OFFBITS-1:0] wb_subword_off_Xhl;
  logic                 wb_en_Xhl, prop_carry_Xhl, carry_in_1_Xhl, flag_reg_en_Xhl;
  logic                 addr_reg_en_Xhl, last_uop_Xhl, mem_access_Xhl;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  param_uop_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .inst_val           (inst_val),
    .inst_rdy           (inst_rdy),
    .inst_rs1           (inst_rs1),
    .inst_rs2           (inst_rs2),
    .inst_rd            (inst_rd),
    .inst_wb_en         (inst_wb_en),
    .inst_is_sub        (inst_is_sub),
    .inst_mem           (inst_mem),
    .dmemresp_val_Xhl   (dmemresp_val_Xhl),
    .rega_addr_Rhl      (rega_addr_Rhl),
    .regb_addr_Rhl      (regb_addr_Rhl),
    .a_subword_off_Rhl  (a_subword_off_Rhl),
    .b_subword_off_Rhl  (b_subword_off_Rhl),
    .wb_addr_Xhl        (wb_addr_Xhl),
    .wb_subword_off_Xhl (wb_subword_off_Xhl),
    .wb_en_Xhl          (wb_en_Xhl),
    .prop_carry_Xhl     (prop_carry_Xhl),
    .carry_in_1_Xhl     (carry_in_1_Xhl),
    .flag_reg_en_Xhl    (flag_reg_en_Xhl),
    .addr_reg_en_Xhl    (addr_reg_en_Xhl),
    .last_uop_Xhl       (last_uop_Xhl),
    .mem_access_Xhl     (mem_access_Xhl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int rs1, input int rs2, input int rd,
                      input bit wb, input bit sub, input bit mem);
    inst_rs1    = 5'(rs1);
    inst_rs2    = 5'(rs2);
    inst_rd     = 5'(rd);
    inst_wb_en  = wb;
    inst_is_sub = sub;
    inst_mem    = mem;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy"}, 32'(inst_rdy), 32'd1);
    chk({tag, "_rega"}, 32'(rega_addr_Rhl), 32'd0);
    chk({tag, "_regb"}, 32'(regb_addr_Rhl), 32'd0);
    chk({tag, "_aoff"}, 32'(a_subword_off_Rhl), 32'd0);
    chk({tag, "_wbaddr"}, 32'(wb_addr_Xhl), 32'd0);
    chk({tag, "_wben"}, 32'(wb_en_Xhl), 32'd0);
    chk({tag, "_flag"}, 32'(flag_reg_en_Xhl), 32'd0);
    chk({tag, "_prop"}, 32'(prop_carry_Xhl), 32'd0);
    chk({tag, "_last"}, 32'(last_uop_Xhl), 32'd0);
    chk({tag, "_mem"}, 32'(mem_access_Xhl), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    inst_val = 1'b0;
    dmemresp_val_Xhl = 1'b0;
    load(0, 0, 0, 0, 0, 0);
    #2;
    chk_quiet("rst");
    #1 reset = 1'b0;
    step();

    // ADD r3 = r1 + r2
    $display("txn ADD rs1=1 rs2=2 rd=3");
    load(1, 2, 3, 1, 0, 0);
    inst_val = 1'b1;
    step();
    inst_val = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc = c;
      chk("add_aoff", 32'(a_subword_off_Rhl), (c <= 8) ? c - 1 : 0);
      chk("add_boff", 32'(b_subword_off_Rhl), (c <= 8) ? c - 1 : 0);
      chk("add_rega", 32'(rega_addr_Rhl), (c <= 8) ? 1 : 0);
      chk("add_regb", 32'(regb_addr_Rhl), (c <= 8) ? 2 : 0);
      chk("add_wben", 32'(wb_en_Xhl), (c >= 2 && c <= 9) ? 1 : 0);
      chk("add_wboff", 32'(wb_subword_off_Xhl), (c >= 2 && c <= 9) ? c - 2 : 0);
      chk("add_wbaddr", 32'(wb_addr_Xhl), (c >= 2 && c <= 9) ? 3 : 0);
      chk("add_prop", 32'(prop_carry_Xhl), (c >= 3 && c <= 9) ? 1 : 0);
      chk("add_cin1", 32'(carry_in_1_Xhl), 32'd0);
      chk("add_last", 32'(last_uop_Xhl), (c == 9) ? 1 : 0);
      chk("add_rdy", 32'(inst_rdy), (c >= 8) ? 1 : 0);
      step();
    end

    // SUB r5
    $display("txn SUB rs1=4 rs2=6 rd=5");
    load(4, 6, 5, 1, 1, 0);
    inst_val = 1'b1;
    step();
    inst_val = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cyc = c;
      chk("sub_cin1", 32'(carry_in_1_Xhl), (c == 2) ? 1 : 0);
      chk("sub_flag", 32'(flag_reg_en_Xhl), (c >= 2 && c <= 9) ? 1 : 0);
      chk("sub_wbaddr", 32'(wb_addr_Xhl), (c >= 2 && c <= 9) ? 5 : 0);
      step();
    end

    // Two ADDs back-to-back with inst_val held high
    $display("txn ADD x2 back-to-back rd=3 then rd=4");
    load(1, 2, 3, 1, 0, 0);
    inst_val = 1'b1;
    step();
    load(10, 11, 4, 1, 0, 0);
    for (int c = 1; c <= 18; c++) begin
      cyc = c;
      if (c == 9) inst_val = 1'b0;
      chk("b2b_wben", 32'(wb_en_Xhl), (c >= 2 && c <= 17) ? 1 : 0);
      chk("b2b_wbaddr", 32'(wb_addr_Xhl), (c >= 2 && c <= 9) ? 3 : (c >= 10 && c <= 17) ? 4 : 0);
      chk("b2b_aoff", 32'(a_subword_off_Rhl), (c <= 8) ? c - 1 : (c <= 16) ? c - 9 : 0);
      chk("b2b_rega", 32'(rega_addr_Rhl), (c <= 8) ? 1 : (c <= 16) ? 10 : 0);
      chk("b2b_last", 32'(last_uop_Xhl), (c == 9 || c == 17) ? 1 : 0);
      chk("b2b_rdy", 32'(inst_rdy), (c == 8 || c >= 16) ? 1 : 0);
      step();
    end

    // LW r7: address phase, then hold in MEM_WAIT for five cycles
    $display("txn LW rs1=9 rd=7");
    load(9, 0, 7, 1, 0, 1);
    inst_val = 1'b1;
    step();
    inst_val = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      cyc = c;
      chk("lw_addren", 32'(addr_reg_en_Xhl), (c >= 2 && c <= 9) ? 1 : 0);
      chk("lw_wben", 32'(wb_en_Xhl), 32'd0);
      chk("lw_last", 32'(last_uop_Xhl), (c == 9) ? 1 : 0);
      chk("lw_memacc", 32'(mem_access_Xhl), (c >= 10) ? 1 : 0);
      chk("lw_rdy", 32'(inst_rdy), 32'd0);
      if (c < 14) step();
    end
    dmemresp_val_Xhl = 1'b1;
    step();
    dmemresp_val_Xhl = 1'b0;
    cyc = 15;
    chk("lw_done_rdy", 32'(inst_rdy), 32'd1);
    chk("lw_done_memacc", 32'(mem_access_Xhl), 32'd0);
    step();

    // Memory response during RUN and at last_uop must be ignored
    $display("txn LW rs1=8 rd=6 with early response");
    load(8, 0, 6, 1, 0, 1);
    dmemresp_val_Xhl = 1'b1;
    inst_val = 1'b1;
    step();
    inst_val = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      cyc = c;
      chk("early_rdy", 32'(inst_rdy), 32'd0);
      chk("early_last", 32'(last_uop_Xhl), (c == 9) ? 1 : 0);
      step();
    end
    dmemresp_val_Xhl = 1'b0;
    cyc = 10;
    chk("early_memacc", 32'(mem_access_Xhl), 32'd1);
    chk("early_rdy_wait", 32'(inst_rdy), 32'd0);
    step();
    cyc = 11;
    chk("early_memacc2", 32'(mem_access_Xhl), 32'd1);
    dmemresp_val_Xhl = 1'b1;
    step();
    dmemresp_val_Xhl = 1'b0;
    cyc = 12;
    chk("early_done_rdy", 32'(inst_rdy), 32'd1);
    step();

    // Reset asserted mid-instruction at R offset 4
    $display("txn ADD rd=2 aborted by reset");
    load(3, 4, 2, 1, 0, 0);
    inst_val = 1'b1;
    step();
    inst_val = 1'b0;
    for (int c = 1; c < 5; c++) step();
    cyc = 5;
    chk("abort_aoff_pre", 32'(a_subword_off_Rhl), 32'd4);
    chk("abort_wben_pre", 32'(wb_en_Xhl), 32'd1);
    reset = 1'b1;
    #1;
    chk_quiet("abort");
    #2 reset = 1'b0;
    for (int c = 6; c <= 8; c++) begin
      step();
      cyc = c;
      chk_quiet("post_abort");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
